// File: rtl/mhsa_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mhsa_mem_pkg
// Purpose  : Shared BAR memory map and read-owner type for the bank arbiter.
// Revision : 1.0
// ============================================================================
package mhsa_mem_pkg;

  localparam int NUM_BARS = 4;

  localparam logic [31:0] BAR_LIMIT = 32'h4000;

  localparam logic [NUM_BARS-1:0][31:0] BAR_BASE = {
    32'h3000, 32'h2000, 32'h1000, 32'h0000
  };

  typedef enum logic {
    OWN_SOC = 1'b0,
    OWN_ACC = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/mhsa_bank_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mhsa_bank_arbiter_if
// Purpose  : SoC, accelerator and SRAM-side signals of the bank arbiter.
// Revision : 1.0
// ============================================================================
interface mhsa_bank_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 12
);
  import mhsa_mem_pkg::*;

  logic                                 acc_mode;
  logic                                 soc_req;
  logic                                 soc_write_en;
  logic [31:0]                          soc_addr;
  logic [WIDTH-1:0]                     soc_data_in;
  logic                                 soc_gnt;
  logic                                 soc_rvalid;
  logic [WIDTH-1:0]                     soc_data_out;
  logic                                 soc_err;
  logic [NUM_BARS-1:0]                  acc_req;
  logic [NUM_BARS-1:0]                  acc_write_en;
  logic [NUM_BARS-1:0][31:0]            acc_addr;
  logic [NUM_BARS-1:0][WIDTH-1:0]       acc_data_in;
  logic [NUM_BARS-1:0]                  acc_gnt;
  logic [NUM_BARS-1:0]                  acc_rvalid;
  logic [NUM_BARS-1:0][WIDTH-1:0]       acc_data_out;
  logic [NUM_BARS-1:0]                  mem_write_en;
  logic [NUM_BARS-1:0][ADDR_W-1:0]      mem_addr;
  logic [NUM_BARS-1:0][WIDTH-1:0]       mem_data_in;
  logic [NUM_BARS-1:0][WIDTH-1:0]       mem_data_out;

  modport slave (
    input  acc_mode,
    input  soc_req, soc_write_en, soc_addr, soc_data_in,
    output soc_gnt, soc_rvalid, soc_data_out, soc_err,
    input  acc_req, acc_write_en, acc_addr, acc_data_in,
    output acc_gnt, acc_rvalid, acc_data_out,
    output mem_write_en, mem_addr, mem_data_in,
    input  mem_data_out
  );

  modport master (
    output acc_mode,
    output soc_req, soc_write_en, soc_addr, soc_data_in,
    input  soc_gnt, soc_rvalid, soc_data_out, soc_err,
    output acc_req, acc_write_en, acc_addr, acc_data_in,
    input  acc_gnt, acc_rvalid, acc_data_out,
    input  mem_write_en, mem_addr, mem_data_in,
    output mem_data_out
  );

endinterface
`default_nettype wire

// File: rtl/mhsa_bank_arb_slice.sv
`default_nettype none
// ============================================================================
// Module   : mhsa_bank_arb_slice
// Purpose  : One bank: SoC/acc priority with starvation override, read return.
// Revision : 1.0
// ============================================================================
module mhsa_bank_arb_slice
  import mhsa_mem_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_mode,
  input  logic              mode_chg,
  input  logic              soc_req,
  input  logic              soc_write_en,
  input  logic [ADDR_W-1:0] soc_addr,
  input  logic [WIDTH-1:0]  soc_data_in,
  output logic              soc_gnt,
  output logic              soc_rvalid,
  output logic [WIDTH-1:0]  soc_data_out,
  input  logic              acc_req,
  input  logic              acc_write_en,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [WIDTH-1:0]  acc_data_in,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [WIDTH-1:0]  acc_data_out,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_data_in,
  input  logic [WIDTH-1:0]  mem_data_out
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_cnt_eff;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_conflict;
  logic             w_override;
  logic             w_rd_issue;
  logic             r_rd_pend;
  owner_e           r_rd_owner;

  always_comb begin
    w_conflict   = soc_req & acc_req;
    // A mode change discards accumulated starvation before it can trigger
    w_cnt_eff    = mode_chg ? '0 : r_wait_cnt;
    w_override   = w_conflict && (w_cnt_eff == CNT_W'(MAX_WAIT));
    acc_gnt      = acc_req & (~soc_req | (acc_mode ^ w_override));
    soc_gnt      = soc_req & ~acc_gnt;
    w_cnt_nxt    = (w_conflict && !w_override) ? (w_cnt_eff + CNT_W'(1)) : '0;
    w_rd_issue   = (acc_gnt & ~acc_write_en) | (soc_gnt & ~soc_write_en);
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    if (acc_gnt) begin
      mem_write_en = acc_write_en;
      mem_addr     = acc_addr;
      mem_data_in  = acc_data_in;
    end else if (soc_gnt) begin
      mem_write_en = soc_write_en;
      mem_addr     = soc_addr;
      mem_data_in  = soc_data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_SOC;
    end else begin
      r_wait_cnt <= w_cnt_nxt;
      r_rd_pend  <= w_rd_issue;
      r_rd_owner <= acc_gnt ? OWN_ACC : OWN_SOC;
    end
  end

  assign soc_rvalid   = r_rd_pend && (r_rd_owner == OWN_SOC);
  assign acc_rvalid   = r_rd_pend && (r_rd_owner == OWN_ACC);
  assign soc_data_out = soc_rvalid ? mem_data_out : '0;
  assign acc_data_out = acc_rvalid ? mem_data_out : '0;

endmodule
`default_nettype wire

// File: rtl/mhsa_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mhsa_bank_arbiter
// Purpose  : SoC/accelerator arbiter over the four BAR SRAMs (x, Wq, Wk, Wv).
// Revision : 1.0
// ============================================================================
module mhsa_bank_arbiter
  import mhsa_mem_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int LENGTH   = 4096,
  parameter int MAX_WAIT = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mhsa_bank_arbiter_if.slave bus
);

  localparam int ADDR_W = $clog2(LENGTH);

  logic                           r_acc_mode;
  logic                           r_oor;
  logic                           w_in_range;
  logic                           w_oor_gnt;
  logic                           w_mode_chg;
  logic [NUM_BARS-1:0]            w_soc_bank_req;
  logic [NUM_BARS-1:0]            w_soc_gnt;
  logic [NUM_BARS-1:0]            w_soc_rvalid;
  logic [NUM_BARS-1:0][WIDTH-1:0] w_soc_rdata;
  logic [WIDTH-1:0]               w_soc_data;

  assign w_in_range = bus.soc_addr < BAR_LIMIT;
  assign w_oor_gnt  = bus.soc_req & ~w_in_range;
  assign w_mode_chg = bus.acc_mode ^ r_acc_mode;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_mode <= 1'b0;
      r_oor      <= 1'b0;
    end else begin
      r_acc_mode <= bus.acc_mode;
      r_oor      <= w_oor_gnt;
    end
  end

  generate
    for (genvar i = 0; i < NUM_BARS; i++) begin : g_bank
      logic w_acc_addr_hi_unused;
      assign w_acc_addr_hi_unused = ^bus.acc_addr[i][31:ADDR_W];
      assign w_soc_bank_req[i] = bus.soc_req && w_in_range &&
                                 (bus.soc_addr[31:12] == BAR_BASE[i][31:12]);

      mhsa_bank_arb_slice #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
      ) u_slice (
        .clk          (clk),
        .rst_n        (rst_n),
        .acc_mode     (bus.acc_mode),
        .mode_chg     (w_mode_chg),
        .soc_req      (w_soc_bank_req[i]),
        .soc_write_en (bus.soc_write_en),
        .soc_addr     (bus.soc_addr[ADDR_W-1:0]),
        .soc_data_in  (bus.soc_data_in),
        .soc_gnt      (w_soc_gnt[i]),
        .soc_rvalid   (w_soc_rvalid[i]),
        .soc_data_out (w_soc_rdata[i]),
        .acc_req      (bus.acc_req[i]),
        .acc_write_en (bus.acc_write_en[i]),
        .acc_addr     (bus.acc_addr[i][ADDR_W-1:0]),
        .acc_data_in  (bus.acc_data_in[i]),
        .acc_gnt      (bus.acc_gnt[i]),
        .acc_rvalid   (bus.acc_rvalid[i]),
        .acc_data_out (bus.acc_data_out[i]),
        .mem_write_en (bus.mem_write_en[i]),
        .mem_addr     (bus.mem_addr[i]),
        .mem_data_in  (bus.mem_data_in[i]),
        .mem_data_out (bus.mem_data_out[i])
      );
    end
  endgenerate

  // Slices zero their SoC data when not returning, so OR is a safe merge
  always_comb begin
    w_soc_data = '0;
    for (int i = 0; i < NUM_BARS; i++) begin
      w_soc_data = w_soc_data | w_soc_rdata[i];
    end
  end

  assign bus.soc_gnt      = w_oor_gnt | (|w_soc_gnt);
  assign bus.soc_rvalid   = r_oor | (|w_soc_rvalid);
  assign bus.soc_err      = r_oor;
  assign bus.soc_data_out = w_soc_data;

endmodule
`default_nettype wire

// File: tb/tb_mhsa_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mhsa_bank_arbiter
// Purpose  : Directed self-checking bench for mhsa_bank_arbiter with SRAM model.
// Revision : 1.0
// ============================================================================
module tb_mhsa_bank_arbiter;
  import mhsa_mem_pkg::*;

  localparam int WIDTH  = 64;
  localparam int ADDR_W = 12;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mhsa_bank_arbiter_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  mhsa_bank_arbiter #(
    .WIDTH    (WIDTH),
    .LENGTH   (4096),
    .MAX_WAIT (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [63:0] pat(input int b, input logic [11:0] a);
    return 64'hC0DE_0000_0000_0000 | (64'(b) << 16) | 64'(a);
  endfunction

  // SRAM model: unwritten words read back a known address pattern
  logic [63:0] mem [4][4096];
  bit          wr  [4][4096];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      bus.mem_data_out[i] <= wr[i][bus.mem_addr[i]] ? mem[i][bus.mem_addr[i]]
                                                    : pat(i, bus.mem_addr[i]);
      if (bus.mem_write_en[i]) begin
        mem[i][bus.mem_addr[i]] <= bus.mem_data_in[i];
        wr[i][bus.mem_addr[i]]  <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.soc_req      = 1'b0;
    bus.soc_write_en = 1'b0;
    bus.soc_addr     = '0;
    bus.soc_data_in  = '0;
    bus.acc_req      = '0;
    bus.acc_write_en = '0;
    bus.acc_addr     = '0;
    bus.acc_data_in  = '0;
  endtask

  task automatic soc_drive(input logic we, input logic [31:0] addr, input logic [63:0] data);
    bus.soc_req      = 1'b1;
    bus.soc_write_en = we;
    bus.soc_addr     = addr;
    bus.soc_data_in  = data;
  endtask

  logic prev_soc;
  int   prev_c;
  logic exp_soc;

  initial begin
    rst_n        = 1'b0;
    bus.acc_mode = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_soc_rvalid", bus.soc_rvalid, 0);
    chk("rst_soc_err", bus.soc_err, 0);
    chk("rst_acc_rvalid", bus.acc_rvalid, 0);
    chk("rst_soc_gnt", bus.soc_gnt, 0);
    tick();

    // Solo SoC write then read on bank 1
    soc_drive(1'b1, 32'h1010, 64'hA5A5);
    #1;
    chk("solo_wr_gnt", bus.soc_gnt, 1);
    chk("solo_wr_acc_gnt", bus.acc_gnt, 0);
    chk("solo_wr_mem_we", bus.mem_write_en, 4'b0010);
    chk("solo_wr_mem_addr", bus.mem_addr[1], 12'h010);
    chk("solo_wr_mem_data", bus.mem_data_in[1], 64'hA5A5);
    tick();
    soc_drive(1'b0, 32'h1010, 64'h0);
    #1;
    chk("solo_rd_gnt", bus.soc_gnt, 1);
    chk("solo_wr_no_rvalid", bus.soc_rvalid, 0);
    tick();
    idle();
    #1;
    chk("solo_rd_rvalid", bus.soc_rvalid, 1);
    chk("solo_rd_data", bus.soc_data_out, 64'hA5A5);
    chk("solo_rd_acc_rvalid", bus.acc_rvalid, 0);
    tick();

    // Bank 2 conflict, accelerator priority: SoC wins every ninth cycle
    bus.acc_mode = 1'b1;
    prev_soc = 1'b0;
    prev_c   = 0;
    for (int c = 0; c < 18; c++) begin
      bus.acc_req      = 4'b0100;
      bus.acc_write_en = 4'b0000;
      bus.acc_addr[2]  = 32'(c);
      soc_drive(1'b0, 32'h2100 + 32'(c), 64'h0);
      #1;
      exp_soc = ((c % 9) == 8);
      chk($sformatf("conf_soc_gnt_%0d", c), bus.soc_gnt, exp_soc);
      chk($sformatf("conf_acc_gnt_%0d", c), bus.acc_gnt, exp_soc ? 4'b0000 : 4'b0100);
      chk($sformatf("conf_mem_addr_%0d", c), bus.mem_addr[2],
          exp_soc ? 12'(12'h100 + c) : 12'(c));
      if (c > 0) begin
        chk($sformatf("conf_soc_rv_%0d", c), bus.soc_rvalid, prev_soc);
        chk($sformatf("conf_acc_rv_%0d", c), bus.acc_rvalid, prev_soc ? 4'b0000 : 4'b0100);
        chk($sformatf("conf_soc_data_%0d", c), bus.soc_data_out,
            prev_soc ? pat(2, 12'(12'h100 + prev_c)) : 64'h0);
        chk($sformatf("conf_acc_data_%0d", c), bus.acc_data_out[2],
            prev_soc ? 64'h0 : pat(2, 12'(prev_c)));
      end
      prev_soc = exp_soc;
      prev_c   = c;
      tick();
    end
    idle();
    #1;
    chk("conf_last_soc_rv", bus.soc_rvalid, 1);
    chk("conf_last_soc_data", bus.soc_data_out, pat(2, 12'h111));
    chk("conf_last_acc_rv", bus.acc_rvalid, 0);
    tick();

    // Parallel banks: acc reads bank 0 while SoC writes bank 3
    bus.acc_req     = 4'b0001;
    bus.acc_addr[0] = 32'h5;
    soc_drive(1'b1, 32'h3007, 64'hDEAD_BEEF);
    #1;
    chk("par_acc_gnt", bus.acc_gnt, 4'b0001);
    chk("par_soc_gnt", bus.soc_gnt, 1);
    chk("par_mem_we", bus.mem_write_en, 4'b1000);
    chk("par_mem_data3", bus.mem_data_in[3], 64'hDEAD_BEEF);
    tick();
    idle();
    soc_drive(1'b0, 32'h3007, 64'h0);
    #1;
    chk("par_acc_rvalid", bus.acc_rvalid, 4'b0001);
    chk("par_acc_data", bus.acc_data_out[0], pat(0, 12'h5));
    chk("par_soc_no_rvalid", bus.soc_rvalid, 0);
    tick();
    idle();
    #1;
    chk("par_rb_rvalid", bus.soc_rvalid, 1);
    chk("par_rb_data", bus.soc_data_out, 64'hDEAD_BEEF);
    tick();

    // Out-of-range read then write
    soc_drive(1'b0, 32'h4000, 64'h0);
    #1;
    chk("oor_gnt", bus.soc_gnt, 1);
    chk("oor_mem_we", bus.mem_write_en, 0);
    chk("oor_mem_addr", bus.mem_addr, 0);
    tick();
    soc_drive(1'b1, 32'h8000, 64'h1);
    #1;
    chk("oor_rd_rvalid", bus.soc_rvalid, 1);
    chk("oor_rd_err", bus.soc_err, 1);
    chk("oor_rd_data", bus.soc_data_out, 0);
    chk("oor_wr_gnt", bus.soc_gnt, 1);
    chk("oor_wr_mem_we", bus.mem_write_en, 0);
    tick();
    idle();
    #1;
    chk("oor_wr_rvalid", bus.soc_rvalid, 1);
    chk("oor_wr_err", bus.soc_err, 1);
    tick();
    #1;
    chk("oor_err_clear", bus.soc_err, 0);
    tick();

    // Mode flip with wait_cnt[1] at 5
    for (int k = 0; k < 5; k++) begin
      bus.acc_req     = 4'b0010;
      bus.acc_addr[1] = 32'(k);
      soc_drive(1'b0, 32'h1020 + 32'(k), 64'h0);
      #1;
      chk($sformatf("flip_pre_acc_gnt_%0d", k), bus.acc_gnt, 4'b0010);
      tick();
    end
    bus.acc_mode = 1'b0;
    for (int k = 0; k < 9; k++) begin
      bus.acc_req     = 4'b0010;
      bus.acc_addr[1] = 32'(k);
      soc_drive(1'b0, 32'h1030 + 32'(k), 64'h0);
      #1;
      chk($sformatf("flip_soc_gnt_%0d", k), bus.soc_gnt, k != 8);
      chk($sformatf("flip_acc_gnt_%0d", k), bus.acc_gnt, (k == 8) ? 4'b0010 : 4'b0000);
      tick();
    end
    idle();
    tick();

    // Reset mid-read: wait_cnt[2] builds up, acc read on bank 1 is dropped
    for (int k = 0; k < 3; k++) begin
      bus.acc_req     = 4'b0100;
      bus.acc_addr[2] = 32'(k);
      soc_drive(1'b0, 32'h2000 + 32'(k), 64'h0);
      #1;
      chk($sformatf("rstpre_soc_gnt_%0d", k), bus.soc_gnt, 1);
      tick();
    end
    bus.acc_req     = 4'b0110;
    bus.acc_addr[1] = 32'h3;
    #1;
    chk("rstrd_acc_gnt", bus.acc_gnt, 4'b0010);
    chk("rstrd_soc_gnt", bus.soc_gnt, 1);
    rst_n = 1'b0;
    tick();
    idle();
    #1;
    chk("rstrd_acc_rvalid", bus.acc_rvalid, 0);
    chk("rstrd_soc_rvalid", bus.soc_rvalid, 0);
    tick();
    rst_n = 1'b1;
    chk("rstrd_acc_rvalid2", bus.acc_rvalid, 0);
    for (int k = 0; k < 9; k++) begin
      bus.acc_req     = 4'b0100;
      bus.acc_addr[2] = 32'(k);
      soc_drive(1'b0, 32'h2040 + 32'(k), 64'h0);
      #1;
      chk($sformatf("rstpost_acc_gnt_%0d", k), bus.acc_gnt, (k == 8) ? 4'b0100 : 4'b0000);
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mhsa_bank_arbiter.md
# mhsa_bank_arbiter

Two-requester, four-bank memory arbiter between the SoC bus and `mhsa_acc_top`, placed in front of the four BAR SRAMs (x, Wq, Wk, Wv). It replaces the static start-based mux with per-bank request/grant handshakes, mode-dependent priority, a bounded-starvation guarantee and registered read-return routing. This lets the SoC access the SRAMs while the accelerator runs.

## Interface
- `WIDTH`, 64, data width of every bank.
- `LENGTH`, 4096, words per bank; `ADDR_W = $clog2(LENGTH)`.
- `MAX_WAIT`, 8, maximum consecutive denied cycles for the lower-priority requester on one bank (≥1).

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `acc_mode`  in  1  1 = accelerator has priority, 0 = SoC has priority.
- `soc_req`  in  1  SoC access request.
- `soc_write_en`  in  1  1 = write, 0 = read.
- `soc_addr`  in  32  byte-free word address; bank = `soc_addr[13:12]`, offset = `soc_addr[11:0]`.
- `soc_data_in`  in  WIDTH  write data.
- `soc_gnt`  out  1  access accepted this cycle.
- `soc_rvalid`  out  1  read data valid (1 cycle after granted read).
- `soc_data_out`  out  WIDTH  read data, 0 when `soc_rvalid`=0.
- `soc_err`  out  1  pulses with `soc_rvalid` for an out-of-range access.
- `acc_req`  in  4  per-bank accelerator request.
- `acc_write_en`  in  4  per-bank write enable.
- `acc_addr`  in  4×32  per-bank address, low ADDR_W bits used.
- `acc_data_in`  in  4×WIDTH  per-bank write data.
- `acc_gnt`  out  4  per-bank grant.
- `acc_rvalid`  out  4  per-bank read valid.
- `acc_data_out`  out  4×WIDTH  per-bank read data, 0 when invalid.
- `mem_write_en`  out  4  to bank i.
- `mem_addr`  out  4×ADDR_W  to bank i.
- `mem_data_in`  out  4×WIDTH  to bank i.
- `mem_data_out`  in  4×WIDTH  from bank i, 1-cycle read latency.

## Operation
- **Decode:**
  - `soc_addr < 32'h4000` targets bank `soc_addr[13:12]`.
  - Otherwise the access is out-of-range. It is granted immediately and touches no bank. `soc_rvalid` and `soc_err` go high next cycle with data 0, including for writes.
- **Per-bank arbitration:**
  - Contenders are the acc request on bank i and an in-range SoC request decoded to bank i.
  - A single requester is always granted.
  - On conflict, the high-priority side (per `acc_mode`) wins unless the bank's starvation override is active.
- **Starvation counter `wait_cnt[i]`:**
  - Increments each cycle the low-priority side requests bank i and is denied.
  - Clears when that side is granted or stops requesting.
  - When `wait_cnt[i] == MAX_WAIT`, the low-priority side wins bank i that cycle and the counter clears.
  - Worst case: granted on the (MAX_WAIT+1)th requesting cycle.
- **Mode change:** any change of `acc_mode` (compared against a registered copy) clears all `wait_cnt` in the same cycle; the new priority applies immediately.
- **Issue:** the granted requester's write_en/addr/data drive `mem_*` of that bank combinationally. When the bank is idle: `mem_write_en`=0, addr=0, data=0.
- **Read return:**
  - Per bank, register `rd_pend[i]` and `rd_owner[i]` (SOC/ACC) on a granted read.
  - Next cycle, route `mem_data_out[i]` to the owner and assert its rvalid.
  - Writes produce no rvalid, except out-of-range SoC accesses as above.
- Requests not granted must be held by the requester; the arbiter keeps no queue.

## Timing
- Grant: combinational, same cycle as request (0-cycle decision).
- Read latency: exactly 1 cycle from grant to rvalid. Back-to-back reads are granted every cycle (full throughput per bank).
- Different banks are independent: SoC on bank k and acc on bank j≠k are both granted in the same cycle.
- **Reset (`rst_n`=0 at an edge):**
  - Clears `wait_cnt`, `rd_pend`, `rd_owner`, the registered `acc_mode` and the error flag.
  - All registered outputs (`soc_rvalid`, `soc_err`, `acc_rvalid`) read 0 the following cycle.
  - A read granted in the cycle reset is applied is dropped, with no rvalid.
- Combinational outputs follow inputs during reset; grants are still computed. Benches drive no requests during reset.

## Structure
- Package `mhsa_mem_pkg`:
  - `NUM_BARS=4`
  - `BAR_BASE` constants `32'h0000/1000/2000/3000`, `BAR_LIMIT=32'h4000`
  - `typedef enum logic {OWN_SOC, OWN_ACC} owner_e`.
- Sub-module `mhsa_bank_arb_slice`, instantiated 4× by generate. It holds one bank's priority logic, `wait_cnt`, `rd_pend`/`rd_owner` and return muxing.
- The top level holds SoC decode, the out-of-range path and the OR-combine of the per-bank SoC grant/rvalid/data.

## Test plan
- **Solo access:** `acc_mode`=0; SoC writes 64'hA5A5 to 0x1010, then reads 0x1010.
  - Required: `soc_gnt` same cycle; `soc_rvalid` one cycle after the read with data 64'hA5A5; `acc_gnt`=0.
- **Conflict with priority:** `acc_mode`=1; acc and SoC both read bank 2 continuously.
  - Required: acc granted cycles 0–7; SoC granted on cycle 8 (MAX_WAIT=8); the pattern repeats.
  - Required: no `rvalid` misrouted; data matches the addresses issued.
- **Parallel banks:** acc reads bank 0 while SoC writes bank 3 in the same cycle.
  - Required: both granted.
  - Required: bank 3 content updated; acc `rvalid[0]` next cycle.
- **Out-of-range:** SoC read 0x4000.
  - Required: `soc_gnt`=1; no `mem_write_en` and no bank address activity; next cycle `soc_rvalid`=`soc_err`=1, data 0.
- **Mode flip:**
  - Setup: `acc_mode`=1 with `wait_cnt[1]`=5.
  - Stimulus: switch to 0.
  - Required: counters clear; SoC wins bank 1 that cycle; acc now starves at most 8 cycles.
- **Reset mid-read:** grant an acc read on bank 1, assert `rst_n`=0 at the next edge.
  - Required: `acc_rvalid[1]` stays 0; all counters 0 after reset.
